aes128_iter_decrypt: RTL and testbench

AES128_ITER_DECRYPT -- requirements
Module: aes128_iter_decrypt

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_inv_sbox.sv | 35 +++
 rtl/aes128_iter_decrypt.sv | 158 +++++++++++++++
 tb/tb_aes128_iter_decrypt.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, S-box, Rcon and FSM state type.
// Used by the iterative decrypt core and reusable by an encrypt core.
package aes_pkg;

  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KEXP  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } aes_state_e;

  localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Rcon byte for 0-based index i (i=0 -> 0x01).
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [6:0] base;
    base = {i, 3'b000};
    return RCON_TBL[7'd79 - base -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = {x, 3'b000};
    return SBOX_TBL[11'd2047 - base -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, one byte, purely combinational.
// Instantiated per state byte in the decrypt round datapath.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] base;

  // Table lookup indexed by the input byte.
  always_comb begin
    base = {a, 3'b000};
    y    = INV_TBL[11'd2047 - base -: 8];
  end

endmodule

// File: rtl/aes128_iter_decrypt.sv
// Iterative AES-128 decrypt: 10 key-expansion cycles, then
// 10 inverse rounds while the key schedule runs backwards.
module aes128_iter_decrypt
  import aes_pkg::*;
#(
  parameter int NK = AES_NK,
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  localparam logic [3:0] LAST = 4'(NR - 1);

  aes_state_e          fsm;
  logic [3:0]          cnt;
  logic [127:0]        ct_r;
  logic [127:0]        st;
  logic [32*NK-1:0]    kreg;

  logic [31:0]  w0, w1, w2, w3;
  logic [7:0]   rc_f, rc_b;
  logic [31:0]  tf, n0, n1, n2, n3;
  logic [31:0]  p0, p1, p2, p3;
  logic [127:0] fwd_key, prev_key;
  logic [127:0] sr, isb, ark, imc;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(
    input logic [31:0] c
  );
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  assign in_ready = (fsm == S_IDLE);
  assign busy     = (fsm != S_IDLE);

  assign {w0, w1, w2, w3} = kreg;
  assign rc_f = rcon(cnt);
  assign rc_b = rcon(LAST - cnt);

  // Forward key step: rk[i] -> rk[i+1].
  assign tf = sub_word({w3[23:0], w3[31:24]}) ^ {rc_f, 24'h0};
  assign n0 = w0 ^ tf;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign fwd_key = {n0, n1, n2, n3};

  // Backward key step: rk[i+1] -> rk[i].
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ sub_word({p3[23:0], p3[31:24]})
                 ^ {rc_b, 24'h0};
  assign prev_key = {p0, p1, p2, p3};

  // InvShiftRows routing plus per-byte inverse S-box.
  for (genvar k = 0; k < 16; k++) begin : g_byte
    localparam int R   = k % 4;
    localparam int C   = k / 4;
    localparam int SRC = 4 * ((C - R + 4) % 4) + R;
    assign sr[127-8*k -: 8] = st[127-8*SRC -: 8];
    aes_inv_sbox u_isb (
      .a (sr[127-8*k -: 8]),
      .y (isb[127-8*k -: 8])
    );
  end

  assign ark = isb ^ prev_key;

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= S_IDLE;
      cnt       <= '0;
      ct_r      <= '0;
      st        <= '0;
      kreg      <= '0;
      pt        <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (fsm)
        S_IDLE: begin
          if (in_valid) begin
            ct_r <= ct;
            kreg <= key;
            cnt  <= '0;
            fsm  <= S_KEXP;
          end
        end
        S_KEXP: begin
          kreg <= fwd_key;
          if (cnt == LAST) begin
            st  <= ct_r ^ fwd_key;
            cnt <= '0;
            fsm <= S_ROUND;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_ROUND: begin
          kreg <= prev_key;
          if (cnt == LAST) begin
            pt        <= ark;
            out_valid <= 1'b1;
            cnt       <= '0;
            fsm       <= S_DONE;
          end else begin
            st  <= imc;
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_iter_decrypt.sv
// Self-checking bench for aes128_iter_decrypt.
// Expected plaintexts are FIPS-197 constants queued at accept time.
module tb_aes128_iter_decrypt;

  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ct = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] pt;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [127:0] sb [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  aes128_iter_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] c, input logic [127:0] k);
    int w;
    w = 0;
    ct = c;
    key = k;
    in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL accept_wait in_ready=%b required 1", in_ready);
      n_bad++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    ct = C1;
    key = K1;
    tick();
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got %b required 1", in_ready);
      n_bad++;
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got %b required 0", out_valid);
      n_bad++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_busy got %b required 0", busy);
      n_bad++;
    end
    n_cmp++;
    if (pt !== 128'h0) begin
      $display("FAIL reset_pt got %h required 0", pt);
      n_bad++;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_no_accept busy=%b required 0", busy);
      n_bad++;
    end
  endtask

  task automatic test_vector(input logic [127:0] c,
                             input logic [127:0] k,
                             input logic [127:0] p);
    int n;
    logic [127:0] e;
    out_ready = 1'b1;
    sb.push_back(p);
    accept(c, k);
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL vec_busy got %b required 1", busy);
      n_bad++;
    end
    wait_out(n);
    n_cmp++;
    if (n != 20) begin
      $display("FAIL vec_latency got %0d required 20", n);
      n_bad++;
    end
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    n_cmp++;
    if (pt !== e) begin
      $display("FAIL vec_pt got %h required %h", pt, e);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL vec_handshake out_valid=%b in_ready=%b required 0/1",
               out_valid, in_ready);
      n_bad++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [127:0] e;
    out_ready = 1'b0;
    sb.push_back(P2);
    accept(C2, K2);
    wait_out(n);
    n_cmp++;
    if (n != 20) begin
      $display("FAIL bp_latency got %0d required 20", n);
      n_bad++;
    end
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    for (int i = 0; i < 15; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || pt !== e || in_ready !== 1'b0) begin
        $display("FAIL bp_hold cycle %0d valid=%b rdy=%b pt=%h required 1/0/%h",
                 i, out_valid, in_ready, pt, e);
        n_bad++;
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL bp_release valid=%b rdy=%b busy=%b required 0/1/0",
               out_valid, in_ready, busy);
      n_bad++;
    end
    n_cmp++;
    if (pt !== e) begin
      $display("FAIL bp_pt_kept got %h required %h", pt, e);
      n_bad++;
    end
  endtask

  task automatic test_input_ignore();
    int n;
    logic [127:0] e;
    out_ready = 1'b1;
    ct = C1;
    key = K1;
    in_valid = 1'b1;
    sb.push_back(P1);
    tick();
    ct = C2;
    key = K2;
    wait_out(n);
    n_cmp++;
    if (n != 20) begin
      $display("FAIL ign_latency got %0d required 20", n);
      n_bad++;
    end
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    n_cmp++;
    if (pt !== e) begin
      $display("FAIL ign_pt1 got %h required %h", pt, e);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL ign_idle in_ready=%b required 1", in_ready);
      n_bad++;
    end
    sb.push_back(P2);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL ign_accept2 busy=%b required 1", busy);
      n_bad++;
    end
    wait_out(n);
    n_cmp++;
    if (n != 20) begin
      $display("FAIL ign_latency2 got %0d required 20", n);
      n_bad++;
    end
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    n_cmp++;
    if (pt !== e) begin
      $display("FAIL ign_pt2 got %h required %h", pt, e);
      n_bad++;
    end
    tick();
  endtask

  task automatic test_reset_midround();
    int n;
    int seen;
    logic [127:0] e;
    out_ready = 1'b1;
    accept(C2, K2);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL rst_mid valid=%b busy=%b rdy=%b required 0/0/1",
               out_valid, busy, in_ready);
      n_bad++;
    end
    n_cmp++;
    if (pt !== 128'h0) begin
      $display("FAIL rst_mid_pt got %h required 0", pt);
      n_bad++;
    end
    seen = 0;
    repeat (25) begin
      tick();
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      $display("FAIL rst_mid_no_output got %0d results required 0", seen);
      n_bad++;
    end
    sb.push_back(P1);
    accept(C1, K1);
    wait_out(n);
    n_cmp++;
    if (n != 20) begin
      $display("FAIL rst_fresh_latency got %0d required 20", n);
      n_bad++;
    end
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    n_cmp++;
    if (pt !== e) begin
      $display("FAIL rst_fresh_pt got %h required %h", pt, e);
      n_bad++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    int w;
    int last;
    logic sel;
    logic [127:0] e;
    out_ready = 1'b1;
    sel = 1'b0;
    last = -1;
    ct = C1;
    key = K1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = 0;
      while (!in_ready && w < 50) begin
        tick();
        w++;
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
        $display("FAIL b2b_idle job %0d in_ready=%b required 1", i, in_ready);
        n_bad++;
      end
      sb.push_back(sel ? P2 : P1);
      tick();
      sel = ~sel;
      ct = sel ? C2 : C1;
      key = sel ? K2 : K1;
      wait_out(n);
      n_cmp++;
      if (n != 20) begin
        $display("FAIL b2b_latency job %0d got %0d required 20", i, n);
        n_bad++;
      end
      e = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      n_cmp++;
      if (pt !== e) begin
        $display("FAIL b2b_pt job %0d got %h required %h", i, pt, e);
        n_bad++;
      end
      if (last >= 0) begin
        n_cmp++;
        if (cyc - last != 22) begin
          $display("FAIL b2b_period job %0d got %0d required 22",
                   i, cyc - last);
          n_bad++;
        end
      end
      last = cyc;
    end
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      $display("FAIL b2b_drain queue=%0d busy=%b required 0/0",
               sb.size(), busy);
      n_bad++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vector(C1, K1, P1);
    test_vector(C2, K2, P2);
    test_backpressure();
    test_input_ignore();
    test_reset_midround();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
